// File: rtl/axis_packet_master.sv
// axis_packet_master: byte FIFO feeding an AXI-stream slave in fixed-length
// packets. A packet is only started once all PKT_LEN bytes are buffered, so
// valid never drops in the middle of a packet.
//
// Optional feature macro: AXIS_PKT_OVF_FLAG_EN adds a sticky 'overflow'
// output that records any write attempted while the FIFO was full.
//
// Stream handshake: a beat transfers on a rising edge where valid & ready.
// valid comes straight from the state register and never looks at ready;
// once raised it stays high, with data/last stable, until that transfer.
module axis_packet_master #(
    parameter int DEPTH   = 16,
    parameter int PKT_LEN = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] wr_data,
    input  logic       wr_en,
    output logic       full,
    output logic [7:0] data,
    output logic       valid,
    output logic       last,
    input  logic       ready,
`ifdef AXIS_PKT_OVF_FLAG_EN
    output logic       overflow,
`endif
    output logic       state_dbg
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(PKT_LEN) + 1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t          state, state_next;
    logic [BW-1:0]   beat, beat_next;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count, count_next;
    logic            push, pop, last_beat;

    // A write while full is dropped even if a pop frees a slot this cycle.
    assign push       = wr_en & ~full;
    assign pop        = valid & ready;
    assign count_next = count + CW'(push) - CW'(pop);
    assign last_beat  = (beat == BW'(PKT_LEN - 1));

    // Output decode: data is forced to zero whenever no beat is offered.
    assign valid     = (state == SEND);
    assign last      = valid & last_beat;
    assign data      = valid ? mem[rd_ptr] : 8'h00;
    assign state_dbg = state;

    // Byte storage; no reset needed since contents are only read when counted.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // FIFO pointers, occupancy and the registered full flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
        end
    end

    // Packet FSM state and beat counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            beat  <= '0;
        end else begin
            state <= state_next;
            beat  <= beat_next;
        end
    end

    // Next state: start a packet once it is fully buffered; after the last
    // beat continue back-to-back only if another whole packet is waiting.
    always_comb begin
        state_next = state;
        beat_next  = beat;
        case (state)
            IDLE: begin
                if (count_next >= CW'(PKT_LEN)) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                if (pop) begin
                    if (last_beat) begin
                        beat_next = '0;
                        if (count_next < CW'(PKT_LEN)) begin
                            state_next = IDLE;
                        end
                    end else begin
                        beat_next = beat + BW'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
                beat_next  = '0;
            end
        endcase
    end

`ifdef AXIS_PKT_OVF_FLAG_EN
    // Sticky record of any write attempted while full.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (wr_en & full) begin
            overflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_axis_packet_master.sv
// Bench for axis_packet_master (DEPTH=16, PKT_LEN=4). A queue-based model of
// the buffered bytes predicts every output on every cycle; directed
// scenarios add literal expectations on the observed beat stream.
module tb_axis_packet_master;

    localparam int DEPTH   = 16;
    localparam int PKT_LEN = 4;

    logic       clk;
    logic       reset_n;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       full;
    logic [7:0] data;
    logic       valid;
    logic       last;
    logic       ready;
    logic       overflow;
    logic       state_dbg;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

`ifndef AXIS_PKT_OVF_FLAG_EN
    assign overflow = 1'b0;
`endif

    axis_packet_master #(.DEPTH(DEPTH), .PKT_LEN(PKT_LEN)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_data   (wr_data),
        .wr_en     (wr_en),
        .full      (full),
        .data      (data),
        .valid     (valid),
        .last      (last),
        .ready     (ready),
`ifdef AXIS_PKT_OVF_FLAG_EN
        .overflow  (overflow),
`endif
        .state_dbg (state_dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] exp_q[$];     // bytes the FIFO must hold, head first
    bit         m_sending;    // a packet is being offered
    int         m_beat;       // beats of current packet already accepted
    bit         m_full;
    bit         m_ovf;

    logic [8:0] got_q[$];     // observed {last,data} per handshake
    int         got_cyc[$];   // cycle of each observed handshake

    task automatic model_reset();
        exp_q.delete();
        m_sending = 0;
        m_beat    = 0;
        m_full    = 0;
        m_ovf     = 0;
    endtask

    initial model_reset();

    // Compare outputs with the model each cycle, then advance the model
    // using the inputs that will be sampled on the coming rising edge.
    always @(negedge clk) begin
        int  cnt;
        bit  push_m, hs_m;
        if (!reset_n) begin
            check("rst_valid", valid, 0);
            check("rst_last",  last,  0);
            check("rst_data",  data,  0);
            check("rst_full",  full,  0);
`ifdef AXIS_PKT_OVF_FLAG_EN
            check("rst_overflow", overflow, 0);
`endif
            model_reset();
        end else begin
            check("valid", valid, m_sending);
            check("state_dbg", state_dbg, m_sending);
            check("last", last, (m_sending && m_beat == PKT_LEN - 1));
            check("data", data, m_sending ? exp_q[0] : 8'h00);
            check("full", full, m_full);
`ifdef AXIS_PKT_OVF_FLAG_EN
            check("overflow", overflow, m_ovf);
`endif
            if (valid && ready) begin
                got_q.push_back({last, data});
                got_cyc.push_back(cyc);
            end
            push_m = wr_en && !m_full;
            hs_m   = m_sending && ready;
            if (wr_en && m_full) m_ovf = 1;
            if (hs_m)   void'(exp_q.pop_front());
            if (push_m) exp_q.push_back(wr_data);
            cnt = exp_q.size();
            if (!m_sending) begin
                if (cnt >= PKT_LEN) begin
                    m_sending = 1;
                    m_beat    = 0;
                end
            end else if (hs_m) begin
                if (m_beat == PKT_LEN - 1) begin
                    m_beat    = 0;
                    m_sending = (cnt >= PKT_LEN);
                end else begin
                    m_beat++;
                end
            end
            m_full = (cnt == DEPTH);
        end
        cyc++;
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        step(1);
        wr_en   = 1'b0;
    endtask

    task automatic check_got(input string name, input int idx, input logic [7:0] b, input logic l);
        if (idx < got_q.size()) begin
            check({name, "_data"}, got_q[idx][7:0], b);
            check({name, "_last"}, got_q[idx][8], l);
        end else begin
            check({name, "_missing"}, idx, got_q.size());
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] bytes4 [4];
        reset_n = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        ready   = 1'b0;
        step(2);
        check("reset_valid", valid, 0);
        check("reset_full",  full,  0);
        reset_n = 1'b1;
        step(1);

        // Basic packet
        bytes4 = '{8'h11, 8'h22, 8'h33, 8'h44};
        ready = 1'b1;
        got_q.delete();
        for (int i = 0; i < 3; i++) begin
            push_byte(bytes4[i]);
            check("basic_no_early_valid", valid, 0);
        end
        push_byte(bytes4[3]);
        check("basic_valid_rise", valid, 1);
        check("basic_first_data", data, 8'h11);
        step(4);
        check("basic_valid_fall", valid, 0);
        check("basic_count", got_q.size(), 4);
        for (int i = 0; i < 4; i++) check_got("basic", i, bytes4[i], (i == 3));

        // Back-pressure
        ready = 1'b0;
        got_q.delete();
        for (int i = 0; i < 4; i++) push_byte(8'hA0 + 8'(i));
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", valid, 1);
            check("stall_data", data, 8'hA0);
            check("stall_last", last, 0);
            step(1);
        end
        ready = 1'b1;
        step(5);
        check("stall_count", got_q.size(), 4);
        for (int i = 0; i < 4; i++) check_got("stall", i, 8'hA0 + 8'(i), (i == 3));

        // Back-to-back
        ready = 1'b0;
        got_q.delete();
        got_cyc.delete();
        for (int i = 0; i < 8; i++) push_byte(8'(i));
        ready = 1'b1;
        step(10);
        check("b2b_count", got_q.size(), 8);
        for (int i = 0; i < 8; i++) check_got("b2b", i, 8'(i), (i == 3 || i == 7));
        for (int i = 0; i + 1 < got_cyc.size(); i++)
            check("b2b_no_gap", got_cyc[i+1] - got_cyc[i], 1);

        // Partial packet
        got_q.delete();
        for (int i = 0; i < 3; i++) push_byte(8'h50 + 8'(i));
        step(3);
        check("partial_hold", valid, 0);
        check("partial_none", got_q.size(), 0);
        push_byte(8'h53);
        check("partial_go", valid, 1);
        step(5);
        check("partial_count", got_q.size(), 4);
        check_got("partial", 3, 8'h53, 1'b1);

        // Full / overflow
        ready = 1'b0;
        got_q.delete();
        for (int i = 0; i < 16; i++) begin
            push_byte(8'h80 + 8'(i));
            if (i == 14) check("not_full_15", full, 0);
        end
        check("full_16", full, 1);
        push_byte(8'hFF);
        check("full_after_drop", full, 1);
`ifdef AXIS_PKT_OVF_FLAG_EN
        check("overflow_set", overflow, 1);
`endif
        ready = 1'b1;
        step(20);
        check("drain_count", got_q.size(), 16);
        for (int i = 0; i < 16; i++) check_got("drain", i, 8'h80 + 8'(i), (i % 4 == 3));
        check("drain_idle", valid, 0);

        // Reset mid-packet
        ready = 1'b0;
        for (int i = 0; i < 4; i++) push_byte(8'hC0 + 8'(i));
        ready = 1'b1;
        step(2);
        check("pre_rst_valid", valid, 1);
        reset_n = 1'b0;
        #1;
        check("midrst_valid", valid, 0);
        check("midrst_last",  last,  0);
        check("midrst_data",  data,  0);
`ifdef AXIS_PKT_OVF_FLAG_EN
        check("midrst_overflow", overflow, 0);
`endif
        step(2);
        reset_n = 1'b1;
        got_q.delete();
        step(3);
        check("post_rst_idle", valid, 0);
        check("post_rst_none", got_q.size(), 0);
        for (int i = 0; i < 4; i++) push_byte(8'hD0 + 8'(i));
        step(5);
        check("post_rst_count", got_q.size(), 4);
        check_got("post_rst", 0, 8'hD0, 1'b0);
        check_got("post_rst", 3, 8'hD3, 1'b1);

        // Random traffic: balanced, then write-heavy to hit full
        for (int i = 0; i < 2000; i++) begin
            wr_en   = ($urandom_range(0, 99) < 55);
            wr_data = 8'($urandom);
            ready   = ($urandom_range(0, 99) < 70);
            step(1);
        end
        for (int i = 0; i < 1500; i++) begin
            wr_en   = ($urandom_range(0, 99) < 80);
            wr_data = 8'($urandom);
            ready   = ($urandom_range(0, 99) < 25);
            step(1);
        end
        wr_en = 1'b0;
        ready = 1'b1;
        step(40);
        check("final_idle", valid, 0);
        check("final_residue_lt_pkt", (exp_q.size() < PKT_LEN), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
